// File: rtl/fetch_pkg.sv
// Shared widths, the fetch-to-decode entry type and PC helpers for the fetch stage.
package fetch_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned BIMODAL_W = 12;
  localparam int unsigned INSN_W    = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = '0;
  localparam logic [ADDR_W-1:0] PC_STEP          = ADDR_W'(4);

  typedef struct packed {
    logic [INSN_W-1:0]    insn;
    logic [ADDR_W-1:0]    pc4;
    logic                 p_dir;
    logic [BIMODAL_W-1:0] bimodal;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry decode-side FIFO; entry 0 is always the head, so decode sees registered data.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [1:0]   count
);

  fetch_entry_t ent_q [2];
  fetch_entry_t ent_d [2];
  logic [1:0]   count_q, count_d;
  logic         pop_ok;
  logic         wr_sel;

  assign pop_ok = pop & (count_q != 2'd0);
  // Slot for the incoming entry after any shift: 0 when empty or popping from one, else 1.
  assign wr_sel = (count_q == 2'd1) ^ pop_ok;

  always_comb begin
    ent_d   = ent_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop_ok};
    if (pop_ok) ent_d[0] = ent_q[1];
    if (push) ent_d[wr_sel] = push_data;
    if (flush) count_d = 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q   <= '{default: '0};
      count_q <= 2'd0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  assign head       = ent_q[0];
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

  push_when_full: assert property (@(posedge clk) disable iff (!reset)
    !(push && count_q == 2'd2));

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: PC register, F1 response capture, next-PC steering and issue control
// feeding a two-entry skid buffer towards decode.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned       SKID_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [ADDR_W-1:0]    fetch_bpredictor_PC,
  output logic                 fetch_bpredictor_valid,
  output logic                 fetch_bpredictor_stall,
  input  logic                 bpredictor_fetch_p_dir,
  input  logic [ADDR_W-1:0]    bpredictor_fetch_target,
  input  logic [BIMODAL_W-1:0] bpredictor_fetch_bimodal,
  input  logic [INSN_W-1:0]    insnMem_data_r,
  input  logic                 execute_fetch_redirect,
  input  logic [ADDR_W-1:0]    execute_fetch_target,
  input  logic                 decode_fetch_ready,
  output logic                 fetch_decode_valid,
  output logic [INSN_W-1:0]    fetch_decode_insn,
  output logic [ADDR_W-1:0]    fetch_decode_PC4,
  output logic                 fetch_decode_p_dir,
  output logic [BIMODAL_W-1:0] fetch_decode_bimodal
);

  logic [ADDR_W-1:0] pc_q, pc_d, f1_pc_q;
  logic              run_q;
  logic              f1_valid_q, f1_valid_d;
  logic [1:0]        skid_count;
  logic              skid_valid;
  logic [2:0]        occ;
  logic              pop, push, taken, issue_ok, issue;
  fetch_entry_t      skid_in, skid_head;

  assign pop   = decode_fetch_ready & skid_valid;
  assign taken = f1_valid_q & bpredictor_fetch_p_dir;
  assign push  = f1_valid_q & ~execute_fetch_redirect;

  // Occupancy once this cycle's F1 response lands and decode pops; a new request needs a
  // free slot for the cycle its response arrives, so the predictor never has to hold data.
  assign occ      = {1'b0, skid_count} + {2'b00, f1_valid_q} - {2'b00, pop};
  assign issue_ok = occ < 3'(SKID_DEPTH);
  assign issue    = run_q & issue_ok;

  always_comb begin
    pc_d       = pc_q;
    // A taken F1 response kills the sequential request issued alongside it.
    f1_valid_d = issue & ~taken & ~execute_fetch_redirect;
    if (execute_fetch_redirect) begin
      pc_d = align_pc(execute_fetch_target);
    end else if (taken) begin
      pc_d = align_pc(bpredictor_fetch_target);
    end else if (issue) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      f1_pc_q    <= RESET_PC;
      f1_valid_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      pc_q       <= pc_d;
      f1_valid_q <= f1_valid_d;
      if (issue) f1_pc_q <= pc_q;
    end
  end

  assign skid_in = '{
    insn:    insnMem_data_r,
    pc4:     f1_pc_q + PC_STEP,
    p_dir:   bpredictor_fetch_p_dir,
    bimodal: bpredictor_fetch_bimodal
  };

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (skid_in),
    .pop        (pop),
    .flush      (execute_fetch_redirect),
    .head       (skid_head),
    .head_valid (skid_valid),
    .count      (skid_count)
  );

  assign fetch_bpredictor_PC    = pc_q;
  assign fetch_bpredictor_valid = issue;
  assign fetch_bpredictor_stall = ~issue_ok;

  assign fetch_decode_valid   = skid_valid;
  assign fetch_decode_insn    = skid_head.insn;
  assign fetch_decode_PC4     = skid_head.pc4;
  assign fetch_decode_p_dir   = skid_head.p_dir;
  assign fetch_decode_bimodal = skid_head.bimodal;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: stub predictor/insn memory, decode scoreboard, PC checks.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_bpredictor_PC;
  logic        fetch_bpredictor_valid;
  logic        fetch_bpredictor_stall;
  logic        bpredictor_fetch_p_dir = 1'b0;
  logic [31:0] bpredictor_fetch_target = '0;
  logic [11:0] bpredictor_fetch_bimodal = '0;
  logic [31:0] insnMem_data_r = '0;
  logic        execute_fetch_redirect;
  logic [31:0] execute_fetch_target;
  logic        decode_fetch_ready;
  logic        fetch_decode_valid;
  logic [31:0] fetch_decode_insn;
  logic [31:0] fetch_decode_PC4;
  logic        fetch_decode_p_dir;
  logic [11:0] fetch_decode_bimodal;

  always #5 clk = ~clk;

  fetch_pc_gen dut (
    .clk                      (clk),
    .reset                    (reset),
    .fetch_bpredictor_PC      (fetch_bpredictor_PC),
    .fetch_bpredictor_valid   (fetch_bpredictor_valid),
    .fetch_bpredictor_stall   (fetch_bpredictor_stall),
    .bpredictor_fetch_p_dir   (bpredictor_fetch_p_dir),
    .bpredictor_fetch_target  (bpredictor_fetch_target),
    .bpredictor_fetch_bimodal (bpredictor_fetch_bimodal),
    .insnMem_data_r           (insnMem_data_r),
    .execute_fetch_redirect   (execute_fetch_redirect),
    .execute_fetch_target     (execute_fetch_target),
    .decode_fetch_ready       (decode_fetch_ready),
    .fetch_decode_valid       (fetch_decode_valid),
    .fetch_decode_insn        (fetch_decode_insn),
    .fetch_decode_PC4         (fetch_decode_PC4),
    .fetch_decode_p_dir       (fetch_decode_p_dir),
    .fetch_decode_bimodal     (fetch_decode_bimodal)
  );

  typedef struct {
    logic [31:0] pc4;
    logic        p_dir;
    int          gap;  // cycles since previous accepted entry, 0 = don't care
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  bit          armed = 0;
  int          ncyc = 0;
  int          last_acc = 0;
  logic [31:0] tk_pc = 32'hDEAD_BEE0;
  logic [31:0] tk_tgt = '0;
  logic [31:0] req_pc = '0;
  logic        req_v = 1'b0;

  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  function automatic logic [11:0] bim_of(input logic [31:0] pc);
    return pc[13:2] ^ 12'h5a5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc4, input logic p_dir, input int gap);
    exp_t e;
    e.pc4   = pc4;
    e.p_dir = p_dir;
    e.gap   = gap;
    sb.push_back(e);
  endtask

  // One cycle: inputs change 1 after the edge, checks follow 2 later.
  task automatic go(input bit rdy, input bit rdr, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    decode_fetch_ready     = rdy;
    execute_fetch_redirect = rdr;
    execute_fetch_target   = tgt;
    #2;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0) break;
      go(1'b1, 1'b0, '0);
    end
    check(name, sb.size(), 0);
    sb.delete();
    armed = 0;
  endtask

  // Predictor / insn memory stub: responds one cycle after each live request.
  always @(negedge clk) begin
    req_pc = fetch_bpredictor_PC;
    req_v  = fetch_bpredictor_valid;
  end

  always @(posedge clk) begin
    #1;
    bpredictor_fetch_p_dir   = req_v && (req_pc == tk_pc);
    bpredictor_fetch_target  = tk_tgt;
    bpredictor_fetch_bimodal = bim_of(req_pc);
    insnMem_data_r           = insn_of(req_pc);
  end

  // Decode-side monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    ncyc++;
    if (reset && fetch_decode_valid && decode_fetch_ready) begin
      if (armed) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_entry: got PC4 %h, want no entry", fetch_decode_PC4);
        end else begin
          e = sb.pop_front();
          check("dec_pc4", fetch_decode_PC4, e.pc4);
          check("dec_p_dir", 32'(fetch_decode_p_dir), 32'(e.p_dir));
          check("dec_insn", fetch_decode_insn, insn_of(e.pc4 - 32'd4));
          check("dec_bimodal", 32'(fetch_decode_bimodal), 32'(bim_of(e.pc4 - 32'd4)));
          if (e.gap != 0) check("dec_gap", ncyc - last_acc, e.gap);
          if (sb.size() == 0) armed = 0;
        end
      end
      last_acc = ncyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    reset                  = 1'b0;
    decode_fetch_ready     = 1'b1;
    execute_fetch_redirect = 1'b0;
    execute_fetch_target   = '0;

    // Reset state, then sequential stream flowing into a taken branch at 0x10.
    go(1'b1, 1'b0, '0);
    go(1'b1, 1'b0, '0);
    check("rst_bp_valid", 32'(fetch_bpredictor_valid), 0);
    check("rst_dec_valid", 32'(fetch_decode_valid), 0);
    check("rst_stall", 32'(fetch_bpredictor_stall), 0);
    check("rst_pc", fetch_bpredictor_PC, 32'h0);
    push_exp(32'h04, 1'b0, 0);
    push_exp(32'h08, 1'b0, 1);
    push_exp(32'h0c, 1'b0, 1);
    push_exp(32'h10, 1'b0, 1);
    push_exp(32'h14, 1'b1, 1);
    push_exp(32'h84, 1'b0, 2);
    push_exp(32'h88, 1'b0, 1);
    armed  = 1;
    tk_pc  = 32'h10;
    tk_tgt = 32'h83;
    @(negedge clk);
    reset = 1'b1;
    go(1'b1, 1'b0, '0);
    check("s1_pc0", fetch_bpredictor_PC, 32'h0);
    check("s1_valid0", 32'(fetch_bpredictor_valid), 1);
    check("s1_dec_valid0", 32'(fetch_decode_valid), 0);
    go(1'b1, 1'b0, '0);
    check("s1_pc1", fetch_bpredictor_PC, 32'h4);
    check("s1_dec_valid1", 32'(fetch_decode_valid), 0);
    go(1'b1, 1'b0, '0);
    check("s1_pc2", fetch_bpredictor_PC, 32'h8);
    check("s1_dec_valid2", 32'(fetch_decode_valid), 1);
    go(1'b1, 1'b0, '0);
    check("s1_pc3", fetch_bpredictor_PC, 32'hc);
    go(1'b1, 1'b0, '0);
    go(1'b1, 1'b0, '0);
    check("s2_killed_pc", fetch_bpredictor_PC, 32'h14);
    go(1'b1, 1'b0, '0);
    check("s2_target_pc", fetch_bpredictor_PC, 32'h80);
    check("s2_target_valid", 32'(fetch_bpredictor_valid), 1);
    drain("s2_drain");

    // Backpressure: decode holds off for five cycles.
    tk_pc  = 32'h120;
    tk_tgt = 32'h300;
    go(1'b1, 1'b1, 32'h100);
    go(1'b1, 1'b0, '0);
    check("s3_redir_pc", fetch_bpredictor_PC, 32'h100);
    check("s3_redir_dec_valid", 32'(fetch_decode_valid), 0);
    push_exp(32'h104, 1'b0, 0);
    push_exp(32'h108, 1'b0, 6);
    push_exp(32'h10c, 1'b0, 1);
    push_exp(32'h110, 1'b0, 1);
    push_exp(32'h114, 1'b0, 1);
    armed = 1;
    go(1'b1, 1'b0, '0);
    go(1'b1, 1'b0, '0);
    go(1'b0, 1'b0, '0);
    check("s3_stall_rise", 32'(fetch_bpredictor_stall), 1);
    check("s3_stall_valid", 32'(fetch_bpredictor_valid), 0);
    for (int i = 0; i < 4; i++) go(1'b0, 1'b0, '0);
    check("s3_hold_stall", 32'(fetch_bpredictor_stall), 1);
    check("s3_hold_pc", fetch_bpredictor_PC, 32'h10c);
    check("s3_hold_head", fetch_decode_PC4, 32'h108);
    go(1'b1, 1'b0, '0);
    check("s3_stall_fall", 32'(fetch_bpredictor_stall), 0);
    check("s3_resume_valid", 32'(fetch_bpredictor_valid), 1);
    check("s3_resume_pc", fetch_bpredictor_PC, 32'h10c);
    for (int i = 0; i < 5; i++) go(1'b1, 1'b0, '0);
    check("s4_taken_issue", fetch_bpredictor_PC, 32'h120);

    // Redirect overrides a taken F1 response while decode pops.
    go(1'b1, 1'b1, 32'h200);
    check("s4_killed_pc", fetch_bpredictor_PC, 32'h124);
    go(1'b1, 1'b0, '0);
    check("s3_drain", sb.size(), 0);
    check("s4_redir_pc", fetch_bpredictor_PC, 32'h200);
    check("s4_redir_valid", 32'(fetch_bpredictor_valid), 1);
    check("s4_redir_dec_valid", 32'(fetch_decode_valid), 0);
    push_exp(32'h204, 1'b0, 0);
    push_exp(32'h208, 1'b0, 1);
    armed = 1;
    go(1'b1, 1'b0, '0);
    check("s4_no_taken_pc", fetch_bpredictor_PC, 32'h204);
    drain("s4_drain");

    // Asynchronous reset between edges, then restart.
    tk_pc = 32'hDEAD_BEE0;
    go(1'b1, 1'b0, '0);
    #3;
    reset = 1'b0;
    #1;
    check("s5_bp_valid", 32'(fetch_bpredictor_valid), 0);
    check("s5_dec_valid", 32'(fetch_decode_valid), 0);
    check("s5_pc", fetch_bpredictor_PC, 32'h0);
    check("s5_stall", 32'(fetch_bpredictor_stall), 0);
    push_exp(32'h04, 1'b0, 0);
    push_exp(32'h08, 1'b0, 1);
    push_exp(32'h0c, 1'b0, 1);
    armed = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    go(1'b1, 1'b0, '0);
    check("s5_pc0", fetch_bpredictor_PC, 32'h0);
    check("s5_valid0", 32'(fetch_bpredictor_valid), 1);
    go(1'b1, 1'b0, '0);
    check("s5_pc1", fetch_bpredictor_PC, 32'h4);
    go(1'b1, 1'b0, '0);
    check("s5_dec_pc4", fetch_decode_PC4, 32'h4);
    drain("s5_drain");

    // Redirect to the top word (low bits masked) and wrap.
    go(1'b1, 1'b1, 32'hFFFF_FFFF);
    go(1'b1, 1'b0, '0);
    check("s6_top_pc", fetch_bpredictor_PC, 32'hFFFF_FFFC);
    check("s6_dec_valid", 32'(fetch_decode_valid), 0);
    push_exp(32'h0, 1'b0, 0);
    push_exp(32'h4, 1'b0, 1);
    armed = 1;
    go(1'b1, 1'b0, '0);
    check("s6_wrap_pc", fetch_bpredictor_PC, 32'h0);
    drain("s6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
